// File: rtl/sync_std_fifo.sv
// Single-clock FIFO with registered read data and occupancy-derived status flags.
// Optional sticky overflow/underflow outputs are enabled by defining STD_FIFO_ERR_FLAGS_EN.
module sync_std_fifo #(
  parameter int WIDTH              = 32,
  parameter int DEPTH              = 32,
  parameter int ALMOST_FULL_COUNT  = 2,
  parameter int ALMOST_EMPTY_COUNT = 1
) (
  input  logic                       rst,
  input  logic                       clk,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           d,
  output logic [WIDTH-1:0]           q,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_empty,
`ifdef STD_FIFO_ERR_FLAGS_EN
  output logic                       overflow,
  output logic                       underflow,
`endif
  output logic                       almost_full
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  // Thresholds saturate so out-of-range parameters give a constant flag instead of wrapping.
  localparam logic [CW-1:0] AF_LEVEL = (ALMOST_FULL_COUNT >= DEPTH) ? '0
                                     : CW'(DEPTH - ALMOST_FULL_COUNT);
  localparam logic [CW-1:0] AE_LEVEL = (ALMOST_EMPTY_COUNT >= DEPTH) ? CW'(DEPTH)
                                     : CW'(ALMOST_EMPTY_COUNT);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic [WIDTH-1:0] q_q,      q_d;
  logic             wr_en,    rd_en;

  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_LEVEL);
  assign almost_empty = (count_q <= AE_LEVEL);
  assign count        = count_q;
  assign q            = q_q;

  // A pop on a full FIFO frees the slot the simultaneous push lands in.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    q_d      = q_q;
    if (wr_en) begin
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    end
    if (rd_en) begin
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      q_d      = mem[rd_ptr_q];
    end
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: storage has no reset so it maps onto RAM; only pointers, count and q are reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      q_q      <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      q_q      <= q_d;
    end
  end

`ifdef STD_FIFO_ERR_FLAGS_EN
  logic overflow_q,  overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q  || (push && full && !pop);
    underflow_d = underflow_q || (pop && empty);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_std_fifo.sv
// Directed bench for sync_std_fifo: a 32-deep instance (almost_full at 24) and a 4-deep instance
// for pointer wrap and full-FIFO push/pop; sticky error flags are checked when STD_FIFO_ERR_FLAGS_EN is set.
module tb_sync_std_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        push32 = 1'b0, pop32 = 1'b0;
  logic [31:0] d32 = '0, q32;
  logic        full32, empty32, ae32, af32;
  logic [5:0]  count32;

  logic        push4 = 1'b0, pop4 = 1'b0;
  logic [7:0]  d4 = '0, q4;
  logic        full4, empty4, ae4, af4;
  logic [2:0]  count4;

`ifdef STD_FIFO_ERR_FLAGS_EN
  logic        ovf32, unf32, ovf4, unf4;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sync_std_fifo #(.WIDTH(32), .DEPTH(32), .ALMOST_FULL_COUNT(8), .ALMOST_EMPTY_COUNT(1)) dut32 (
    .rst(rst), .clk(clk), .push(push32), .pop(pop32), .d(d32), .q(q32),
    .full(full32), .empty(empty32), .count(count32), .almost_empty(ae32),
`ifdef STD_FIFO_ERR_FLAGS_EN
    .overflow(ovf32), .underflow(unf32),
`endif
    .almost_full(af32)
  );

  sync_std_fifo #(.WIDTH(8), .DEPTH(4), .ALMOST_FULL_COUNT(1), .ALMOST_EMPTY_COUNT(1)) dut4 (
    .rst(rst), .clk(clk), .push(push4), .pop(pop4), .d(d4), .q(q4),
    .full(full4), .empty(empty4), .count(count4), .almost_empty(ae4),
`ifdef STD_FIFO_ERR_FLAGS_EN
    .overflow(ovf4), .underflow(unf4),
`endif
    .almost_full(af4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock on the 32-deep FIFO; outputs are sampled 1 time unit after the edge.
  task automatic cyc32(input logic p, input logic o, input logic [31:0] v);
    push32 = p; pop32 = o; d32 = v;
    @(posedge clk); #1;
    push32 = 1'b0; pop32 = 1'b0;
  endtask

  task automatic cyc4(input logic p, input logic o, input logic [7:0] v);
    push4 = p; pop4 = o; d4 = v;
    @(posedge clk); #1;
    push4 = 1'b0; pop4 = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Reset state
    check("rst_count", 32'(count32), 0);
    check("rst_empty", 32'(empty32), 1);
    check("rst_full",  32'(full32),  0);
    check("rst_ae",    32'(ae32),    1);
    check("rst_af",    32'(af32),    0);
    check("rst_q",     q32,          0);
    check("rst_empty4", 32'(empty4), 1);
    check("rst_af4",    32'(af4),    0);
`ifdef STD_FIFO_ERR_FLAGS_EN
    check("rst_ovf", 32'(ovf32), 0);
    check("rst_unf", 32'(unf32), 0);
`endif

    // Basic order
    cyc32(1, 0, 32'h11);
    check("q_no_fallthrough", q32, 0);
    cyc32(1, 0, 32'h22);
    cyc32(1, 0, 32'h33);
    check("basic_count", 32'(count32), 3);
    check("basic_empty", 32'(empty32), 0);
    check("basic_ae",    32'(ae32),    0);
    cyc32(0, 1, '0);
    check("basic_q0", q32, 32'h11);
    cyc32(0, 1, '0);
    check("basic_q1", q32, 32'h22);
    cyc32(0, 1, '0);
    check("basic_q2", q32, 32'h33);
    check("basic_empty_after", 32'(empty32), 1);
    check("basic_count_after", 32'(count32), 0);

    // Fill to capacity, almost_full at 24 and full at 32
    for (int i = 0; i < 32; i++) begin
      cyc32(1, 0, 32'(i));
      check($sformatf("fill_count_%0d", i), 32'(count32), 32'(i + 1));
      check($sformatf("fill_af_%0d", i),    32'(af32),    32'((i + 1) >= 24));
      check($sformatf("fill_full_%0d", i),  32'(full32),  32'((i + 1) == 32));
    end
    cyc32(1, 0, 32'd99);
    check("drop_count", 32'(count32), 32);
    check("drop_full",  32'(full32),  1);
    check("drop_q",     q32,          32'h33);
`ifdef STD_FIFO_ERR_FLAGS_EN
    check("drop_ovf", 32'(ovf32), 1);
    check("drop_unf", 32'(unf32), 0);
`endif
    for (int i = 0; i < 32; i++) begin
      cyc32(0, 1, '0);
      check($sformatf("drain_q_%0d", i), q32, 32'(i));
    end
    check("drain_empty", 32'(empty32), 1);

    // Underflow: q holds the last popped word
    cyc32(0, 1, '0);
    check("unf_q",     q32,          32'd31);
    check("unf_count", 32'(count32), 0);
`ifdef STD_FIFO_ERR_FLAGS_EN
    check("unf_flag", 32'(unf32), 1);
    check("ovf_sticky", 32'(ovf32), 1);
`endif

    // Simultaneous push/pop on empty: push taken, pop ignored
    cyc32(1, 1, 32'hA5);
    check("pp_empty_count", 32'(count32), 1);
    check("pp_empty_q",     q32,          32'd31);
    cyc32(0, 1, '0);
    check("pp_empty_pop_q", q32, 32'hA5);
    check("pp_empty_count2", 32'(count32), 0);

    // Wrap-around on the 4-deep instance
    for (int k = 0; k < 10; k++) begin
      cyc4(1, 0, 8'(2 * k));
      cyc4(1, 0, 8'(2 * k + 1));
      check($sformatf("wrap_count_%0d", k), 32'(count4), 2);
      cyc4(0, 1, '0);
      check($sformatf("wrap_qa_%0d", k), 32'(q4), 32'(2 * k));
      cyc4(0, 1, '0);
      check($sformatf("wrap_qb_%0d", k), 32'(q4), 32'(2 * k + 1));
    end
    check("wrap_empty", 32'(empty4), 1);

    // Simultaneous push/pop on full 4-deep FIFO
    cyc4(1, 0, 8'h1);
    cyc4(1, 0, 8'h2);
    cyc4(1, 0, 8'h3);
    check("af4_at3", 32'(af4), 1);
    cyc4(1, 0, 8'h4);
    check("full4", 32'(full4), 1);
    cyc4(1, 1, 8'h7);
    check("ppfull_count", 32'(count4), 4);
    check("ppfull_full",  32'(full4),  1);
    check("ppfull_q",     32'(q4),     1);
`ifdef STD_FIFO_ERR_FLAGS_EN
    check("ppfull_no_ovf", 32'(ovf4), 0);
`endif
    cyc4(0, 1, '0); check("ppfull_q2", 32'(q4), 2);
    cyc4(0, 1, '0); check("ppfull_q3", 32'(q4), 3);
    cyc4(0, 1, '0); check("ppfull_q4", 32'(q4), 4);
    cyc4(0, 1, '0); check("ppfull_q7", 32'(q4), 7);
    check("ppfull_empty", 32'(empty4), 1);

    // Asynchronous reset mid-operation with 5 words queued and q nonzero
    for (int i = 0; i < 5; i++) cyc32(1, 0, 32'(32'h40 + i));
    check("arst_pre_count", 32'(count32), 5);
    check("arst_pre_q",     q32,          32'hA5);
    #2 rst = 1'b0;
    #1;
    check("arst_count", 32'(count32), 0);
    check("arst_empty", 32'(empty32), 1);
    check("arst_q",     q32,          0);
`ifdef STD_FIFO_ERR_FLAGS_EN
    check("arst_ovf", 32'(ovf32), 0);
    check("arst_unf", 32'(unf32), 0);
`endif
    @(posedge clk); #1;
    check("arst_hold_count", 32'(count32), 0);
    rst = 1'b1;
    cyc32(1, 0, 32'h55);
    cyc32(1, 0, 32'h66);
    check("post_count", 32'(count32), 2);
    cyc32(0, 1, '0);
    check("post_q0", q32, 32'h55);
    cyc32(0, 1, '0);
    check("post_q1", q32, 32'h66);
    check("post_empty", 32'(empty32), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
